// File: rtl/stage_i_pkg.sv
// stage_i_pkg: shared fetch-stage constants, line geometry and FSM state encoding
package stage_i_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
    localparam int          LINE_WORDS   = 4;
    typedef enum logic [1:0] {
        INIT      = 2'd0,
        LOOKUP    = 2'd1,
        FILL_REQ  = 2'd2,
        FILL_DATA = 2'd3
    } state_e;
endpackage

// File: rtl/stage_i_icache_ram.sv
// icache_ram: direct-mapped tag+valid and data arrays, synchronous read, one write port each
module icache_ram #(
    parameter int IDX_W = 6,
    parameter int OFF_W = 2,
    parameter int TAG_W = 22
) (
    input  logic                   clock,
    input  logic [IDX_W-1:0]       rd_idx_i,
    input  logic [IDX_W+OFF_W-1:0] rd_waddr_i,
    input  logic                   tag_we_i,
    input  logic [IDX_W-1:0]       tag_widx_i,
    input  logic [TAG_W-1:0]       tag_wdata_i,
    input  logic                   tag_wvld_i,
    input  logic                   data_we_i,
    input  logic [IDX_W+OFF_W-1:0] data_waddr_i,
    input  logic [31:0]            data_wdata_i,
    output logic [TAG_W-1:0]       tag_o,
    output logic                   vld_o,
    output logic [31:0]            data_o
);
    logic [TAG_W:0] tag_mem [2**IDX_W];
    logic [31:0]    data_mem [2**(IDX_W+OFF_W)];

    always_ff @(posedge clock) begin
        if (tag_we_i) tag_mem[tag_widx_i] <= {tag_wvld_i, tag_wdata_i};
        {vld_o, tag_o} <= tag_mem[rd_idx_i];
    end

    always_ff @(posedge clock) begin
        if (data_we_i) data_mem[data_waddr_i] <= data_wdata_i;
        data_o <= data_mem[rd_waddr_i];
    end
endmodule

// File: rtl/stage_i.sv
// stage_i: instruction fetch stage with direct-mapped I$, line refill and redirect handling
module stage_i import stage_i_pkg::*; #(
    parameter logic [31:0] RESET_PC      = RESET_PC_DEF,
    parameter int          IC_LINES_LOG2 = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        x_restart,
    input  logic [31:0] x_restart_pc,
    input  logic        d_restart,
    input  logic [31:0] d_restart_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        i_valid,
    output logic [31:0] i_instr,
    output logic [31:0] i_pc,
    output logic [31:0] i_npc
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = IC_LINES_LOG2;
    localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;

    state_e           state_q;
    logic [IDX_W-1:0] init_idx_q;
    logic [31:0]      fetch_pc_q, lk_pc_q, pend_pc_q;
    logic             lk_vld_q, pend_vld_q;
    logic [OFF_W-1:0] beat_q;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_vld;
    logic [31:0]      rd_data;
    logic             redir, hit, last_beat;
    logic [31:0]      redir_pc;

    assign redir     = x_restart | d_restart;
    assign redir_pc  = (x_restart ? x_restart_pc : d_restart_pc) & ~32'h3;
    assign hit       = rd_vld && rd_tag == lk_pc_q[31 -: TAG_W];
    assign last_beat = state_q == FILL_DATA && imem_rsp_valid && beat_q == OFF_W'(LINE_WORDS - 1);

    assign imem_req_valid = state_q == FILL_REQ;
    assign imem_req_addr  = fetch_pc_q & ~32'(4 * LINE_WORDS - 1);
    assign i_valid        = state_q == LOOKUP && lk_vld_q && hit;
    assign i_instr        = i_valid ? rd_data : '0;
    assign i_pc           = i_valid ? lk_pc_q : '0;
    assign i_npc          = i_valid ? lk_pc_q + 32'd4 : '0;

    // fetch_pc_q holds the missed pc for the whole fill, so it indexes both tag and data writes
    icache_ram #(.IDX_W(IDX_W), .OFF_W(OFF_W), .TAG_W(TAG_W)) u_ram (
        .clock        (clock),
        .rd_idx_i     (fetch_pc_q[2+OFF_W +: IDX_W]),
        .rd_waddr_i   (fetch_pc_q[2 +: IDX_W+OFF_W]),
        .tag_we_i     (state_q == INIT || last_beat),
        .tag_widx_i   (state_q == INIT ? init_idx_q : fetch_pc_q[2+OFF_W +: IDX_W]),
        .tag_wdata_i  (fetch_pc_q[31 -: TAG_W]),
        .tag_wvld_i   (state_q != INIT),
        .data_we_i    (state_q == FILL_DATA && imem_rsp_valid),
        .data_waddr_i ({fetch_pc_q[2+OFF_W +: IDX_W], beat_q}),
        .data_wdata_i (imem_rsp_data),
        .tag_o        (rd_tag),
        .vld_o        (rd_vld),
        .data_o       (rd_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= INIT;
            init_idx_q <= '0;
            fetch_pc_q <= RESET_PC;
            lk_pc_q    <= '0;
            lk_vld_q   <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_pc_q  <= '0;
            beat_q     <= '0;
        end else begin
            if (redir && (state_q == FILL_REQ || state_q == FILL_DATA)) begin
                pend_vld_q <= 1'b1;
                pend_pc_q  <= redir_pc;
            end
            case (state_q)
                INIT: begin
                    init_idx_q <= init_idx_q + 1'b1;
                    if (&init_idx_q) begin
                        state_q    <= LOOKUP;
                        fetch_pc_q <= RESET_PC;
                    end
                end
                LOOKUP: begin
                    if (redir) begin
                        fetch_pc_q <= redir_pc;
                        lk_vld_q   <= 1'b0;
                    end else if (lk_vld_q && !hit) begin
                        fetch_pc_q <= lk_pc_q;
                        lk_vld_q   <= 1'b0;
                        state_q    <= FILL_REQ;
                    end else begin
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                        lk_pc_q    <= fetch_pc_q;
                        lk_vld_q   <= 1'b1;
                    end
                end
                FILL_REQ: if (imem_req_ready) state_q <= FILL_DATA;
                FILL_DATA: if (imem_rsp_valid) begin
                    beat_q <= beat_q + 1'b1;
                    if (last_beat) begin
                        state_q    <= LOOKUP;
                        pend_vld_q <= 1'b0;
                        fetch_pc_q <= redir ? redir_pc : pend_vld_q ? pend_pc_q : fetch_pc_q;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_stage_i.sv
// tb_stage_i: directed scoreboard bench for the fetch stage and its I$ refill path
module tb_stage_i;
    logic        clock, reset_n;
    logic        x_restart, d_restart, imem_req_ready, imem_rsp_valid;
    logic [31:0] x_restart_pc, d_restart_pc, imem_rsp_data;
    logic        imem_req_valid, i_valid;
    logic [31:0] imem_req_addr, i_instr, i_pc, i_npc;
    logic [31:0] sb [$];
    int          total = 0, bad = 0;

    stage_i dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .x_restart      (x_restart),
        .x_restart_pc   (x_restart_pc),
        .d_restart      (d_restart),
        .d_restart_pc   (d_restart_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .i_valid        (i_valid),
        .i_instr        (i_instr),
        .i_pc           (i_pc),
        .i_npc          (i_npc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_redir(input int kind, input logic [31:0] pc);
        x_restart    = kind >= 2;
        d_restart    = kind == 1 || kind == 3;
        x_restart_pc = pc;
        d_restart_pc = kind == 3 ? pc ^ 32'h0000_0100 : pc;
    endtask

    task automatic push_run(input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) sb.push_back(a + 32'(4 * i));
    endtask

    always @(negedge clock) begin
        if (reset_n && i_valid) begin
            if (sb.size() == 0) chk("unexpected_valid", 32'(i_valid), 32'd0);
            else begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("i_pc", i_pc, e);
                chk("i_instr", i_instr, mem_word(e));
                chk("i_npc", i_npc, e + 32'd4);
            end
        end
    end

    task automatic wait_req(input string tag, input logic [31:0] exp_addr, input int exp_valids, input int exp_cycles);
        int n, nv, first, last;
        n = 0; nv = 0; first = -1; last = -1;
        while (!imem_req_valid && n < 400) begin
            tick();
            n++;
            if (i_valid) begin
                nv++;
                if (first < 0) first = n;
                last = n;
            end
        end
        chk({tag, "_req_seen"}, 32'(imem_req_valid), 32'd1);
        chk({tag, "_req_addr"}, imem_req_addr, exp_addr);
        chk({tag, "_valid_cnt"}, 32'(nv), 32'(exp_valids));
        if (nv > 0) chk({tag, "_no_bubble"}, 32'(last - first + 1), 32'(nv));
        if (exp_cycles > 0) chk({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
    endtask

    // rb = -1 fires the redirect while the request is still waiting for ready
    task automatic fill(input logic [31:0] addr, input int rb, input int kind, input logic [31:0] rpc);
        chk("hold_valid", 32'(imem_req_valid), 32'd1);
        chk("hold_addr0", imem_req_addr, addr);
        if (rb < 0 && kind != 0) set_redir(kind, rpc);
        tick();
        set_redir(0, 32'h0);
        chk("hold_addr1", imem_req_addr, addr);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("req_drop", 32'(imem_req_valid), 32'd0);
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
                tick();
            end
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(addr + 32'(4 * b));
            if (b == rb) set_redir(kind, rpc);
            tick();
            set_redir(0, 32'h0);
            chk("fill_ivalid", 32'(i_valid), 32'd0);
        end
        imem_rsp_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] cur;
        reset_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        set_redir(0, 32'h0);
        repeat (3) tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_i_valid", 32'(i_valid), 32'd0);
        chk("rst_i_pc", i_pc, 32'd0);
        chk("rst_i_instr", i_instr, 32'd0);
        chk("rst_i_npc", i_npc, 32'd0);
        reset_n = 1'b1;
        wait_req("boot", 32'hBFC0_0000, 0, 66);
        for (int l = 0; l < 4; l++) begin
            cur = 32'hBFC0_0000 + 32'(16 * l);
            push_run(cur, 4);
            fill(cur, 0, 0, 32'h0);
            wait_req("seq", cur + 32'd16, 4, 0);
        end
        push_run(32'hBFC0_0000, 20);
        fill(32'hBFC0_0040, -1, 2, 32'hBFC0_0000);
        wait_req("warm", 32'hBFC0_0050, 20, 0);
        fill(32'hBFC0_0050, 1, 1, 32'h8000_0002);
        wait_req("d_pend", 32'h8000_0000, 0, 0);
        push_run(32'hBFC0_0018, 18);
        fill(32'h8000_0000, 1, 1, 32'hBFC0_0018);
        wait_req("d_beat1", 32'hBFC0_0060, 18, 0);
        push_run(32'hBFC0_0060, 2);
        fill(32'hBFC0_0060, 0, 0, 32'h0);
        tick();
        tick();
        set_redir(3, 32'h8000_0100);
        tick();
        set_redir(0, 32'h0);
        chk("xd_squash", 32'(i_valid), 32'd0);
        push_run(32'h8000_0100, 4);
        wait_req("xd_prio", 32'h8000_0100, 0, 0);
        fill(32'h8000_0100, 0, 0, 32'h0);
        wait_req("after_x", 32'h8000_0110, 4, 0);
        push_run(32'h8000_0110, 1);
        push_run(32'h8000_0000, 4);
        fill(32'h8000_0110, 0, 0, 32'h0);
        tick();
        set_redir(1, 32'h8000_0000);
        tick();
        set_redir(0, 32'h0);
        chk("d_squash", 32'(i_valid), 32'd0);
        tick();
        chk("d_hit_valid", 32'(i_valid), 32'd1);
        chk("d_hit_pc", i_pc, 32'h8000_0000);
        wait_req("d_hit", 32'h8000_0010, 3, 0);
        fill(32'h8000_0010, 0, 2, 32'h8000_0400);
        wait_req("alias_first", 32'h8000_0400, 0, 0);
        cur = 32'h8000_0400;
        for (int k = 0; k < 4; k++) begin
            push_run(cur, 4);
            fill(cur, 0, 0, 32'h0);
            wait_req("alias_run", cur + 32'd16, 4, 0);
            fill(cur + 32'd16, 2, 1, cur ^ 32'h400);
            wait_req("alias_miss", cur ^ 32'h400, 0, 0);
            cur = cur ^ 32'h400;
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(cur + 32'(4 * b));
            tick();
        end
        imem_rsp_data = 32'hBAD0_0002;
        #1 reset_n = 1'b0;
        #1;
        chk("abort_req_valid", 32'(imem_req_valid), 32'd0);
        chk("abort_i_valid", 32'(i_valid), 32'd0);
        chk("abort_i_pc", i_pc, 32'd0);
        chk("abort_i_instr", i_instr, 32'd0);
        chk("abort_i_npc", i_npc, 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        imem_rsp_valid = 1'b0;
        wait_req("reinit", 32'hBFC0_0000, 0, 63);
        push_run(32'hBFC0_0000, 4);
        fill(32'hBFC0_0000, 0, 0, 32'h0);
        wait_req("post_rst", 32'hBFC0_0010, 4, 0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
